// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin share of one single-port data memory between two requesters.
// Latency: gnt same cycle as req in IDLE; store write strobe next cycle; load rvalid two cycles after gnt.
// Backpressure: one access in flight; requests outside IDLE are held off (no gnt) until the arbiter returns to IDLE.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   reqN/weN/sbN/addrN/wdataN  requester N (0 = core LSU, 1 = debug/loader); req held until gntN or errN
//   gntN                       accept pulse, combinational in the IDLE cycle; request captured at that edge
//   errN                       reject pulse (out of range, or misaligned when alignment checking is built in)
//   rvalidN, rdata             load response; rdata is shared and stays put until the next load completes
//   memAddress/memWriteData/memWrite/memSb/memData   registered memory-side interface, combinational-read memory
//
// Build option: define DMEM_ARB_ALIGN_CHECK_EN to reject word accesses whose addr[1:0] != 0.
module data_mem_arbiter #(
  parameter int MEM_BYTES = 8192,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              sb0,
  input  logic              sb1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWrite,
  output logic              memSb,
  input  logic [DATA_W-1:0] memData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;

  // lastGrant resets to 1 so that port 0 wins the first tie.
  logic lastGrant;
  logic curPort;     // port owning the access in flight
  logic curLoad;     // access in flight is a load

  // Selected request (the would-be winner) and its qualification.
  logic              winner;
  logic              anyReq;
  logic              selWe;
  logic              selSb;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              isByte;
  logic [ADDR_W:0]   addrExt;
  logic [ADDR_W:0]   lastByte;
  logic              outOfRange;
  logic              misalign;
  logic              selBad;
  logic              decide;

  always_comb begin
    anyReq   = req0 | req1;
    // Sole requester wins; on a tie the port that did not win last time goes.
    winner   = (req0 && req1) ? ~lastGrant : req1;
    selWe    = winner ? we1    : we0;
    selSb    = winner ? sb1    : sb0;
    selAddr  = winner ? addr1  : addr0;
    selWdata = winner ? wdata1 : wdata0;

    // Loads are always word accesses; only a store may be a byte access.
    isByte   = selWe & selSb;

    // One extra bit so addr+3 cannot wrap past the top of the address space.
    addrExt    = {1'b0, selAddr};
    lastByte   = isByte ? addrExt : addrExt + (ADDR_W+1)'(3);
    outOfRange = lastByte >= (ADDR_W+1)'(MEM_BYTES);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    misalign = ~isByte & (selAddr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif

    selBad = outOfRange | misalign;

    // Gated by rst_n so no accept/reject pulse is seen while reset is held.
    decide = rst_n & (state == IDLE) & anyReq;

    gnt0 = decide & ~selBad & ~winner;
    gnt1 = decide & ~selBad &  winner;
    err0 = decide &  selBad & ~winner;
    err1 = decide &  selBad &  winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lastGrant    <= 1'b1;
      curPort      <= 1'b0;
      curLoad      <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata        <= '0;
      memAddress   <= '0;
      memWriteData <= '0;
      memWrite     <= 1'b0;
      memSb        <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            // A rejected access still counts as this port's turn.
            lastGrant <= winner;
            if (!selBad) begin
              memAddress   <= selAddr;
              memWriteData <= selWdata;
              memSb        <= isByte;
              memWrite     <= selWe;
              curPort      <= winner;
              curLoad      <= ~selWe;
              state        <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Address is left untouched here so the strobe falls while it is still stable.
          memWrite <= 1'b0;
          if (curLoad) begin
            rdata   <= memData;
            rvalid0 <= ~curPort;
            rvalid1 <=  curPort;
            state   <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          memWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule
